alu_pipe: RTL and testbench

//  Parametrised, 2-stage pipelined successor to the 16-bit datapath ALU. Same op

---
 rtl/alu_pipe_if.sv | 29 ++
 rtl/alu_pipe.sv | 126 ++++++++++++
 tb/tb_alu_pipe.sv | 305 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// Operand/result handshake bundle for alu_pipe: valid/ready on both sides plus payload and flags.
interface alu_pipe_if #(
    parameter int unsigned WIDTH = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in1;
    logic [WIDTH-1:0] in2;
    logic [3:0]       op;
    logic             neg1;
    logic             neg2;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out;
    logic             cOut;
    logic             ovf;
    logic             zero;
    logic             gZero;

    modport master (
        output in_valid, in1, in2, op, neg1, neg2, out_ready,
        input  in_ready, out_valid, out, cOut, ovf, zero, gZero
    );

    modport slave (
        input  in_valid, in1, in2, op, neg1, neg2, out_ready,
        output in_ready, out_valid, out, cOut, ovf, zero, gZero
    );
endinterface

// File: rtl/alu_pipe.sv
// Two-stage pipelined ALU: S1 holds conditioned operands, S2 holds the registered result and flags.
module alu_pipe #(
    parameter int unsigned WIDTH = 16
) (
    input  logic          clk,
    input  logic          rst,
    alu_pipe_if.slave     bus
);
    localparam int unsigned SHW  = $clog2(WIDTH);
    localparam int unsigned HALF = WIDTH / 2;

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [3:0]       op;
    } s1_t;

    typedef struct packed {
        logic [WIDTH-1:0] res;
        logic             cout;
        logic             ovf;
        logic             zero;
        logic             gzero;
    } s2_t;

    logic s1_valid;
    logic s2_valid;
    s1_t  s1_q;
    s1_t  s1_d;
    s2_t  s2_q;
    s2_t  s2_d;
    logic s2_adv_c;

    // Operand conditioning happens before S1 so the stage holds in1c/in2c directly.
    always_comb begin
        s1_d    = '0;
        s1_d.a  = bus.neg1 ? (~bus.in1 + WIDTH'(1)) : bus.in1;
        s1_d.b  = bus.neg2 ? ~bus.in2 : bus.in2;
        s1_d.op = bus.op;
    end

    assign s2_adv_c     = !s2_valid || bus.out_ready;
    assign bus.in_ready = !s1_valid || s2_adv_c;

    always_ff @(posedge clk) begin
        if (!rst) begin
            s1_valid <= 1'b0;
            s1_q     <= '0;
        end else if (bus.in_ready) begin
            s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                s1_q <= s1_d;
            end
        end
    end

    // Result datapath evaluated on the S1 contents.
    always_comb begin
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [SHW-1:0]   sh;
        logic [WIDTH:0]   sum;
        logic             add_ovf;
        logic [WIDTH-1:0] rev;

        a       = s1_q.a;
        b       = s1_q.b;
        sh      = s1_q.b[SHW-1:0];
        sum     = {1'b0, a} + {1'b0, b};
        add_ovf = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
        rev     = '0;
        for (int i = 0; i < int'(WIDTH); i++) begin
            rev[i] = a[int'(WIDTH) - 1 - i];
        end

        s2_d = '0;
        casez (s1_q.op)
            4'b0000: s2_d.res = a << sh;
            4'b0001: s2_d.res = a >> sh;
            4'b0010: s2_d.res = (a << sh) | (a >> (WIDTH - 32'(sh)));
            4'b0011: s2_d.res = (a >> sh) | (a << (WIDTH - 32'(sh)));
            4'b0100: begin
                s2_d.res  = sum[WIDTH-1:0];
                s2_d.cout = sum[WIDTH];
                s2_d.ovf  = add_ovf;
            end
            4'b0101: s2_d.res = a & b;
            4'b0110: s2_d.res = a ^ b;
            4'b0111: begin
                s2_d.ovf = add_ovf;
                if (!add_ovf) begin
                    s2_d.res = sum[WIDTH-1:0];
                end else if (a[WIDTH-1]) begin
                    s2_d.res = {1'b1, {(WIDTH-1){1'b0}}};
                end else begin
                    s2_d.res = {1'b0, {(WIDTH-1){1'b1}}};
                end
            end
            4'b10??: s2_d.res = rev;
            4'b11??: s2_d.res = {a[HALF-1:0], b[HALF-1:0]};
            default: ;
        endcase
        s2_d.zero  = (s2_d.res == '0);
        s2_d.gzero = !s2_d.res[WIDTH-1] && (s2_d.res != '0);
    end

    // S2 only loads when the consumer side can advance; otherwise the result is held.
    always_ff @(posedge clk) begin
        if (!rst) begin
            s2_valid <= 1'b0;
            s2_q     <= '0;
        end else if (s2_adv_c) begin
            s2_valid <= s1_valid;
            if (s1_valid) begin
                s2_q <= s2_d;
            end
        end
    end

    assign bus.out_valid = s2_valid;
    assign bus.out       = s2_q.res;
    assign bus.cOut      = s2_q.cout;
    assign bus.ovf       = s2_q.ovf;
    assign bus.zero      = s2_q.zero;
    assign bus.gZero     = s2_q.gzero;
endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed vectors, backpressure/reset sequences, random stream vs model.
module tb_alu_pipe;
    typedef struct packed {
        logic [15:0] out;
        logic        c;
        logic        v;
        logic        z;
        logic        g;
    } res_t;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [3:0]  op;
        logic        n1;
        logic        n2;
        logic [15:0] eo;
        logic        ec;
        logic        ev;
        logic        ez;
        logic        eg;
    } vec_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    alu_pipe_if #(.WIDTH(16)) bus ();
    alu_pipe_if #(.WIDTH(32)) bus32 ();

    alu_pipe #(.WIDTH(16)) dut   (.clk(clk), .rst(rst), .bus(bus));
    alu_pipe #(.WIDTH(32)) dut32 (.clk(clk), .rst(rst), .bus(bus32));

    int   n_cmp = 0;
    int   n_bad = 0;
    int   n_del = 0;
    res_t exp_q[$];
    logic stalled = 1'b0;
    res_t held;
    vec_t vecs[20];

    // Reference: arithmetic on integers, straight from the operation definitions.
    function automatic res_t model(logic [15:0] a, logic [15:0] b, logic [3:0] op, logic n1, logic n2);
        longint M, x, y, sx, sy, ss, r, p, q;
        int     sh;
        logic   c, v, ov;
        M  = 65536;
        x  = n1 ? (M - longint'(a)) % M : longint'(a);
        y  = n2 ? (M - 1 - longint'(b)) : longint'(b);
        sh = int'(y % 16);
        p  = longint'(1) << sh;
        q  = longint'(1) << (16 - sh);
        sx = (x >= 32768) ? x - M : x;
        sy = (y >= 32768) ? y - M : y;
        ss = sx + sy;
        ov = (ss > 32767) || (ss < -32768);
        c  = 1'b0;
        v  = 1'b0;
        r  = 0;
        case (op)
            4'd0: r = (x * p) % M;
            4'd1: r = x / p;
            4'd2: r = (x * p) % M + x / q;
            4'd3: r = x / p + (x * q) % M;
            4'd4: begin
                r = (x + y) % M;
                c = ((x + y) >= M);
                v = ov;
            end
            4'd5: r = x & y;
            4'd6: r = x ^ y;
            4'd7: begin
                v = ov;
                r = !ov ? (x + y) % M : ((ss < 0) ? 32768 : 32767);
            end
            4'd8, 4'd9, 4'd10, 4'd11: begin
                for (int i = 0; i < 16; i++) begin
                    if (((x >> i) & 1) == 1) r = r + (longint'(1) << (15 - i));
                end
            end
            default: r = (x % 256) * 256 + (y % 256);
        endcase
        return {16'(r), c, v, (r == 0), (r != 0) && (r < 32768)};
    endfunction

    function automatic res_t dut_res();
        return {bus.out, bus.cOut, bus.ovf, bus.zero, bus.gZero};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock: settle, account handshakes against the scoreboard, advance to posedge+1.
    task automatic cycle();
        logic acc, del;
        #1;
        acc = rst && bus.in_valid && bus.in_ready;
        del = rst && bus.out_valid && bus.out_ready;
        if (stalled) begin
            check("hold_valid", 64'(bus.out_valid), 64'(1));
            check("hold_data", 64'(dut_res()), 64'(held));
        end
        stalled = rst && bus.out_valid && !bus.out_ready;
        held    = dut_res();
        if (del) begin
            n_del++;
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_bad++;
                $display("FAIL spurious_out: got delivery of 0x%0h, expected none", bus.out);
            end else begin
                check("sb_result", 64'(dut_res()), 64'(exp_q.pop_front()));
            end
        end
        if (acc) exp_q.push_back(model(bus.in1, bus.in2, bus.op, bus.neg1, bus.neg2));
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) cycle();
        rst = 1'b1;
        exp_q.delete();
        stalled = 1'b0;
    endtask

    task automatic check_idle(input string tag);
        #1;
        check({tag, "_out_valid"}, 64'(bus.out_valid), 64'(0));
        check({tag, "_out"}, 64'(bus.out), 64'(0));
        check({tag, "_flags"}, 64'({bus.cOut, bus.ovf, bus.zero, bus.gZero}), 64'(0));
        check({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    endtask

    task automatic drive_rand();
        bus.in1  = 16'($urandom());
        bus.in2  = 16'($urandom());
        bus.op   = 4'($urandom_range(0, 15));
        bus.neg1 = 1'($urandom_range(0, 1));
        bus.neg2 = 1'($urandom_range(0, 1));
    endtask

    task automatic drain(input string tag);
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int k = 0; k < 20 && exp_q.size() > 0; k++) cycle();
        cycle();
        check({tag, "_drain_empty"}, 64'(exp_q.size()), 64'(0));
    endtask

    task automatic run32(input string name, input logic [31:0] a, input logic [31:0] b,
                         input logic [3:0] op, input logic [31:0] eo, input logic ec);
        bus32.in1      = a;
        bus32.in2      = b;
        bus32.op       = op;
        bus32.in_valid = 1'b1;
        @(posedge clk);
        #1;
        bus32.in_valid = 1'b0;
        @(posedge clk);
        #1;
        check({name, "_valid"}, 64'(bus32.out_valid), 64'(1));
        check({name, "_out"}, 64'(bus32.out), 64'(eo));
        check({name, "_cout"}, 64'(bus32.cOut), 64'(ec));
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int d0;
        vecs[0]  = '{16'hFFFF, 16'h0001, 4'h4, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[1]  = '{16'h0003, 16'h0000, 4'h4, 1'b1, 1'b1, 16'hFFFC, 1'b1, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h8001, 16'h0004, 4'h2, 1'b0, 1'b0, 16'h0018, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[3]  = '{16'h8001, 16'h0004, 4'h3, 1'b0, 1'b0, 16'h1800, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4]  = '{16'h0001, 16'h0000, 4'h8, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[5]  = '{16'h12AB, 16'h34CD, 4'hC, 1'b0, 1'b0, 16'hABCD, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[6]  = '{16'h7FFF, 16'h0001, 4'h7, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1, 1'b0, 1'b1};
        vecs[7]  = '{16'h8000, 16'hFFFF, 4'h7, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[8]  = '{16'h0005, 16'h0003, 4'h7, 1'b0, 1'b0, 16'h0008, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[9]  = '{16'h1234, 16'h0010, 4'h0, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[10] = '{16'hF000, 16'h0004, 4'h1, 1'b0, 1'b0, 16'h0F00, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[11] = '{16'h8000, 16'h8000, 4'h4, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0};
        vecs[12] = '{16'hF0F0, 16'hFF00, 4'h5, 1'b0, 1'b0, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[13] = '{16'h00FF, 16'h0F0F, 4'h6, 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[14] = '{16'h7FFF, 16'h0001, 4'h4, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 1'b0};
        vecs[15] = '{16'h1234, 16'h00F0, 4'h2, 1'b0, 1'b0, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[16] = '{16'h0000, 16'h0000, 4'h6, 1'b0, 1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[17] = '{16'h0002, 16'h0000, 4'h4, 1'b1, 1'b0, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};
        vecs[18] = '{16'h0001, 16'h0001, 4'h0, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[19] = '{16'h00FF, 16'h0001, 4'hD, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0};

        rst = 1'b0;
        bus.in_valid = 1'b0; bus.out_ready = 1'b0;
        bus.in1 = '0; bus.in2 = '0; bus.op = '0; bus.neg1 = 1'b0; bus.neg2 = 1'b0;
        bus32.in_valid = 1'b0; bus32.out_ready = 1'b1;
        bus32.in1 = '0; bus32.in2 = '0; bus32.op = '0; bus32.neg1 = 1'b0; bus32.neg2 = 1'b0;

        do_reset(2);
        check_idle("rst0");

        // Directed vectors, one op at a time through an empty pipe.
        bus.out_ready = 1'b1;
        foreach (vecs[i]) begin
            bus.in1 = vecs[i].a; bus.in2 = vecs[i].b; bus.op = vecs[i].op;
            bus.neg1 = vecs[i].n1; bus.neg2 = vecs[i].n2;
            bus.in_valid = 1'b1;
            cycle();
            bus.in_valid = 1'b0;
            check($sformatf("vec%0d_early", i), 64'(bus.out_valid), 64'(0));
            cycle();
            check($sformatf("vec%0d_valid", i), 64'(bus.out_valid), 64'(1));
            check($sformatf("vec%0d_out", i), 64'(bus.out), 64'(vecs[i].eo));
            check($sformatf("vec%0d_flags", i), 64'({bus.cOut, bus.ovf, bus.zero, bus.gZero}),
                  64'({vecs[i].ec, vecs[i].ev, vecs[i].ez, vecs[i].eg}));
            cycle();
        end
        drain("vec");

        // Backpressure: two ops fill the pipe, the third waits, then three emerge back to back.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in1 = 16'h0010; bus.in2 = 16'h0020; bus.op = 4'h4; bus.neg1 = 1'b0; bus.neg2 = 1'b0;
        cycle();
        bus.in1 = 16'h0F0F; bus.in2 = 16'h00FF; bus.op = 4'h6;
        cycle();
        bus.in1 = 16'h0001; bus.in2 = 16'h0003; bus.op = 4'h0;
        #1;
        check("bp_in_ready", 64'(bus.in_ready), 64'(0));
        repeat (3) cycle();
        check("bp_held_out", 64'(bus.out), 64'(16'h0030));
        check("bp_queue", 64'(exp_q.size()), 64'(2));
        bus.out_ready = 1'b1;
        d0 = n_del;
        for (int k = 0; k < 3; k++) begin
            check($sformatf("bp_stream%0d_valid", k), 64'(bus.out_valid), 64'(1));
            cycle();
            bus.in_valid = 1'b0;
        end
        check("bp_after_valid", 64'(bus.out_valid), 64'(0));
        check("bp_delivered", 64'(n_del - d0), 64'(3));
        drain("bp");

        // Full throughput with an always-ready consumer.
        d0 = n_del;
        for (int k = 0; k < 8; k++) begin
            drive_rand();
            bus.in_valid = 1'b1;
            #1;
            check($sformatf("tput%0d_ready", k), 64'(bus.in_ready), 64'(1));
            cycle();
        end
        bus.in_valid = 1'b0;
        cycle();
        cycle();
        check("tput_delivered", 64'(n_del - d0), 64'(8));
        drain("tput");

        // Mid-stream reset discards everything in flight.
        for (int k = 0; k < 20; k++) begin
            drive_rand();
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 3) == 0);
            cycle();
        end
        bus.in_valid = 1'b1;
        do_reset(2);
        check_idle("mrst");
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        d0 = n_del;
        repeat (6) cycle();
        check("mrst_no_old", 64'(n_del - d0), 64'(0));

        // Random stream with random valid/ready on both sides.
        for (int k = 0; k < 10000; k++) begin
            drive_rand();
            bus.in_valid  = 1'($urandom_range(0, 3) != 0);
            bus.out_ready = 1'($urandom_range(0, 3) != 0);
            cycle();
        end
        drain("rand");

        // Wider datapath spot checks.
        run32("w32_rotl", 32'h8000_0001, 32'h0000_0021, 4'h2, 32'h0000_0003, 1'b0);
        run32("w32_rotr", 32'h0000_0003, 32'h0000_0001, 4'h3, 32'h8000_0001, 1'b0);
        run32("w32_add", 32'hFFFF_FFFF, 32'h0000_0002, 4'h4, 32'h0000_0001, 1'b1);
        run32("w32_cat", 32'h1234_ABCD, 32'h5678_EF01, 4'hC, 32'hABCD_EF01, 1'b0);
        run32("w32_rev", 32'h0000_0001, 32'h0000_0000, 4'h8, 32'h8000_0000, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
